// File: rtl/key_expansion_iter_if.sv
// Control and round-key read bundle for the iterative AES key schedule.
`timescale 1ns/1ps
interface key_expansion_iter_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         err;
  logic         key_valid;
  logic [3:0]   num_rounds;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic         rd_valid;
  logic [127:0] rd_key;

  modport master (
    output start, key_len, key_in,
    output rd_en, rd_round,
    input  busy, done, err,
    input  key_valid, num_rounds,
    input  rd_valid, rd_key
  );

  modport slave (
    input  start, key_len, key_in,
    input  rd_en, rd_round,
    output busy, done, err,
    output key_valid, num_rounds,
    output rd_valid, rd_key
  );
endinterface

// File: rtl/key_expansion_iter.sv
// Iterative AES-128/192/256 key schedule, one word per cycle,
// with a 60-word store and a registered round-key read port.
`timescale 1ns/1ps
module key_expansion_iter #(
  parameter bit ENABLE_192 = 1'b1,
  parameter bit ENABLE_256 = 1'b1
) (
  input logic clk,
  input logic rst_n,
  key_expansion_iter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, LOAD, EXPAND
  } state_t;

  state_t       state;
  logic [1:0]   len;
  logic [255:0] key;
  logic [5:0]   idx;
  logic [2:0]   m;
  logic [7:0]   rcon;
  logic [31:0]  mem [60];
  logic [31:0]  win [8];

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // GF(2^8) inverse as x^254, then the AES affine map
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] p3, p7, p15, p31, p63, p127, v;
    p3   = gmul(gmul(x, x), x);
    p7   = gmul(gmul(p3, p3), x);
    p15  = gmul(gmul(p7, p7), x);
    p31  = gmul(gmul(p15, p15), x);
    p63  = gmul(gmul(p31, p31), x);
    p127 = gmul(gmul(p63, p63), x);
    v    = gmul(p127, p127);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
             ^ 8'h63;
  endfunction

  logic [3:0]   nk;
  logic [3:0]   nr;
  logic [5:0]   last;
  logic [31:0]  prev;
  logic [31:0]  far;
  logic [31:0]  sub_in;
  logic [31:0]  sub;
  logic [31:0]  temp;
  logic [31:0]  new_w;
  logic [255:0] ks;
  logic         legal;
  logic         m_last;
  logic         rd_ok;
  logic [5:0]   ri;

  always_comb begin
    nk   = 4'd4;
    nr   = 4'd10;
    last = 6'd43;
    far  = win[4];
    unique case (1'b1)
      len == 2'b01: begin
        nk = 4'd6; nr = 4'd12;
        last = 6'd51; far = win[2];
      end
      len == 2'b10: begin
        nk = 4'd8; nr = 4'd14;
        last = 6'd59; far = win[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    prev   = win[7];
    sub_in = (m == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub    = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
              sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    temp   = prev;
    if (m == 3'd0)
      temp = sub ^ {rcon, 24'h0};
    else if (nk == 4'd8 && m == 3'd4)
      temp = sub;
    new_w  = far ^ temp;
    m_last = (m == 3'(nk - 4'd1));
    ks     = key >> {4'd8 - nk, 5'd0};
  end

  assign legal = (bus.key_len == 2'b00)
              || (bus.key_len == 2'b01 && ENABLE_192)
              || (bus.key_len == 2'b10 && ENABLE_256);
  assign ri    = {bus.rd_round, 2'b00};
  assign rd_ok = bus.rd_en && bus.key_valid
              && (bus.rd_round <= bus.num_rounds);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      len            <= 2'b00;
      key            <= '0;
      idx            <= '0;
      m              <= '0;
      rcon           <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.key_valid  <= 1'b0;
      bus.num_rounds <= '0;
      bus.rd_valid   <= 1'b0;
      bus.rd_key     <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.rd_valid <= rd_ok;
      if (rd_ok)
        bus.rd_key <= {mem[ri], mem[ri | 6'd1],
                       mem[ri | 6'd2], mem[ri | 6'd3]};
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (legal) begin
              key            <= bus.key_in;
              len            <= bus.key_len;
              bus.key_valid  <= 1'b0;
              bus.num_rounds <= '0;
              bus.busy       <= 1'b1;
              state          <= LOAD;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        LOAD: begin
          idx   <= {2'b00, nk};
          m     <= '0;
          rcon  <= 8'h01;
          state <= EXPAND;
        end
        EXPAND: begin
          idx <= idx + 6'd1;
          m   <= m_last ? 3'd0 : m + 3'd1;
          if (m == 3'd0) rcon <= xt(rcon);
          if (idx == last) begin
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            bus.key_valid  <= 1'b1;
            bus.num_rounds <= nr;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store and window carry no reset; key_valid guards reads.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int k = 0; k < 8; k++) begin
        mem[k] <= key[255 - 32*k -: 32];
        win[k] <= ks[255 - 32*k -: 32];
      end
    end else if (state == EXPAND) begin
      mem[idx] <= new_w;
      for (int k = 0; k < 7; k++)
        win[k] <= win[k+1];
      win[7] <= new_w;
    end
  end
endmodule
